// File: rtl/regwb_pkg.sv
// Shared constants and FIFO entry type for the register-file write-side controller.
package regwb_pkg;

  localparam logic [4:0]  REG_LINK    = 5'd31;
  localparam logic [31:0] LINK_OFFSET = 32'd2;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

  // reg_num holds the destination register ("reg" is a reserved word)
  typedef struct packed {
   logic        valid;
   logic        killed;
   logic [4:0]  reg_num;
   logic [31:0] data;
  } regwb_entry_t;

endpackage

// File: rtl/regwb_if.sv
// Datapath / long-latency unit / register-file signals of reg_writeback_ctrl.
interface regwb_if;

   logic        pri_valid;
   logic [4:0]  pri_reg;
   logic [31:0] pri_data;
   logic        jal;
   logic [31:0] pc;
   logic        sec_valid;
   logic        sec_ready;
   logic [4:0]  sec_reg;
   logic [31:0] sec_data;
   logic        signal_reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] pending_mask;
   logic        pri_stall;

   modport master (
      output pri_valid, pri_reg, pri_data, jal, pc, sec_valid, sec_reg, sec_data,
      input  sec_ready, signal_reg_write, write_reg, write_data, pending_mask, pri_stall
   );

   modport slave (
      input  pri_valid, pri_reg, pri_data, jal, pc, sec_valid, sec_reg, sec_data,
      output sec_ready, signal_reg_write, write_reg, write_data, pending_mask, pri_stall
   );

endinterface

// File: rtl/regwb_fifo.sv
// Secondary result FIFO: storage, pointers, occupancy, per-entry kill and pending mask.
module regwb_fifo
   import regwb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [4:0]   push_reg,
   input  logic [31:0]  push_data,
   input  logic         pop,
   input  logic         kill_en,
   input  logic [4:0]   kill_reg,
   output logic         ready,
   output regwb_entry_t head,
   output logic [31:0]  pending_mask
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   regwb_entry_t  mem   [DEPTH];
   regwb_entry_t  mem_n [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          push_ok;
   logic          pop_ok;
   logic [31:0]   mask_n;

   assign ready   = (count != CW'(DEPTH));
   assign head    = mem[rd_ptr];
   assign push_ok = push && ready;
   assign pop_ok  = pop && head.valid;

   // Killed entries keep their slot until popped; a push matching the kill is born killed.
   always_comb begin
      mask_n = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_n[i] = mem[i];
         if (kill_en && mem[i].valid && (mem[i].reg_num == kill_reg))
            mem_n[i].killed = 1'b1;
      end
      if (pop_ok)
         mem_n[rd_ptr].valid = 1'b0;
      if (push_ok)
         mem_n[wr_ptr] = '{valid:   1'b1,
                           killed:  kill_en && (push_reg == kill_reg),
                           reg_num: push_reg,
                           data:    push_data};
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (mem_n[i].valid && !mem_n[i].killed)
            mask_n[mem_n[i].reg_num] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         pending_mask <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= mem_n[i];
         pending_mask <= mask_n;
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write port arbiter: jal > datapath > FIFO head, with program-order kill.
// Optional starvation guard compiled in with REGWB_STARVE_GUARD_EN.
module reg_writeback_ctrl
   import regwb_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic     clk,
   input logic     rst,
   regwb_if.slave  bus
);

   if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
      $error("reg_writeback_ctrl: DEPTH must be a power of two in 2..8 and STARVE_LIMIT >= 1");
   end

   regwb_entry_t head;
   logic         fifo_ready;
   logic [31:0]  fifo_mask;
   logic         stall;
   logic         pop_req;
   logic         kill_en;
   logic [4:0]   kill_reg;
   logic         sel_we;
   logic [4:0]   sel_reg;
   logic [31:0]  sel_data;
   logic [31:0]  link_data;
   logic         we_q;
   logic [4:0]   reg_q;
   logic [31:0]  data_q;

   assign link_data = bus.pc + LINK_OFFSET;

   always_comb begin
      sel_we   = 1'b0;
      sel_reg  = REG_ZERO;
      sel_data = '0;
      kill_en  = 1'b0;
      kill_reg = REG_ZERO;
      pop_req  = 1'b0;
      if (bus.jal && !stall) begin
         sel_we   = 1'b1;
         sel_reg  = REG_LINK;
         sel_data = link_data;
         kill_en  = 1'b1;
         kill_reg = REG_LINK;
      end else if (bus.pri_valid && !stall) begin
         sel_we   = 1'b1;
         sel_reg  = bus.pri_reg;
         sel_data = bus.pri_data;
         kill_en  = 1'b1;
         kill_reg = bus.pri_reg;
      end else begin
         pop_req  = 1'b1;
         sel_we   = head.valid && !head.killed;
         sel_reg  = head.reg_num;
         sel_data = head.data;
      end
      if (sel_reg == REG_ZERO)
         sel_we = 1'b0;
   end

   regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (bus.sec_valid),
      .push_reg     (bus.sec_reg),
      .push_data    (bus.sec_data),
      .pop          (pop_req),
      .kill_en      (kill_en),
      .kill_reg     (kill_reg),
      .ready        (fifo_ready),
      .head         (head),
      .pending_mask (fifo_mask)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         reg_q  <= REG_ZERO;
         data_q <= '0;
      end else begin
         we_q   <= sel_we;
         reg_q  <= sel_we ? sel_reg : REG_ZERO;
         data_q <= sel_we ? sel_data : '0;
      end
   end

`ifdef REGWB_STARVE_GUARD_EN
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt;
   logic          stall_q;

   // stall_q rises when the count reaches the limit; the forced pop then clears both
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else if (pop_req && head.valid) begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else if (head.valid) begin
         starve_cnt <= starve_cnt + SW'(1);
         stall_q    <= ((starve_cnt + SW'(1)) == SW'(STARVE_LIMIT));
      end else begin
         stall_q    <= 1'b0;
      end
   end

   assign stall = stall_q;
`else
   assign stall = 1'b0;
`endif

   assign bus.signal_reg_write = we_q;
   assign bus.write_reg        = reg_q;
   assign bus.write_data       = data_q;
   assign bus.pending_mask     = fifo_mask;
   assign bus.sec_ready        = fifo_ready;
   assign bus.pri_stall        = stall;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: vector table plus scoreboarded write port.
`timescale 1ns/1ps
module tb_reg_writeback_ctrl;

   logic clk = 1'b0;
   logic rst;

   regwb_if bus ();

   reg_writeback_ctrl #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic        pv;
      logic [4:0]  pr;
      logic [31:0] pd;
      logic        j;
      logic [31:0] pc;
      logic        we;
      logic [4:0]  er;
      logic [31:0] ed;
   } vec_t;

   wr_t  exp_q[$];
   vec_t tbl[10];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic exp_wr(input logic [4:0] r, input logic [31:0] d);
      wr_t e;
      e.r = r;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pri_valid = 1'b0;
      bus.jal       = 1'b0;
      bus.sec_valid = 1'b0;
   endtask

   task automatic pri(input logic [4:0] r, input logic [31:0] d);
      bus.pri_valid = 1'b1;
      bus.pri_reg   = r;
      bus.pri_data  = d;
   endtask

   task automatic sec(input logic [4:0] r, input logic [31:0] d);
      bus.sec_valid = 1'b1;
      bus.sec_reg   = r;
      bus.sec_data  = d;
   endtask

   // Every write appearing on the port must match the next expected write in order.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (bus.signal_reg_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=r%0d:%h required=no_write",
                     bus.write_reg, bus.write_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_reg", {27'd0, bus.write_reg}, {27'd0, e.r});
            chk("wr_data", bus.write_data, e.d);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      logic stall_seen;

      tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF};
      tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  32'h0};
      tbl[2] = '{1'b1, 5'd7,  32'h00000077, 1'b1, 32'h00000100, 1'b1, 5'd31, 32'h00000102};
      tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  32'h0};
      tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hFFFFFFFF, 1'b1, 5'd31, 32'h00000001};
      tbl[5] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0};
      tbl[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1, 5'd31, 32'hCAFEF00D};
      tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hFFFFFFFE, 1'b1, 5'd31, 32'h00000000};
      tbl[8] = '{1'b1, 5'd1,  32'h00000000, 1'b0, 32'h0,        1'b1, 5'd1,  32'h00000000};
      tbl[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  32'h0};

      rst          = 1'b1;
      bus.pri_reg  = '0;
      bus.pri_data = '0;
      bus.pc       = '0;
      bus.sec_reg  = '0;
      bus.sec_data = '0;
      idle();
      cyc();
      cyc();
      chk("rst_we",    {31'd0, bus.signal_reg_write}, 32'd0);
      chk("rst_reg",   {27'd0, bus.write_reg}, 32'd0);
      chk("rst_data",  bus.write_data, 32'd0);
      chk("rst_mask",  bus.pending_mask, 32'd0);
      chk("rst_stall", {31'd0, bus.pri_stall}, 32'd0);
      chk("rst_ready", {31'd0, bus.sec_ready}, 32'd1);
      rst = 1'b0;

      // Primary / link vectors: one cycle each, write visible after the next edge.
      foreach (tbl[i]) begin
         bus.pri_valid = tbl[i].pv;
         bus.pri_reg   = tbl[i].pr;
         bus.pri_data  = tbl[i].pd;
         bus.jal       = tbl[i].j;
         bus.pc        = tbl[i].pc;
         if (tbl[i].we)
            exp_wr(tbl[i].er, tbl[i].ed);
         cyc();
         chk("tbl_we", {31'd0, bus.signal_reg_write}, {31'd0, tbl[i].we});
      end
      idle();

      // Secondary latency with idle primary: two cycles to the port.
      sec(5'd12, 32'h00001212);
      exp_wr(5'd12, 32'h00001212);
      cyc();
      bus.sec_valid = 1'b0;
      chk("sec_lat_t1", {31'd0, bus.signal_reg_write}, 32'd0);
      cyc();
      chk("sec_lat_t2", {31'd0, bus.signal_reg_write}, 32'd1);
      cyc();

      // Fill the FIFO behind a busy primary, offer a third while full, then drain.
      pri(5'd3, 32'h30); sec(5'd9, 32'h11); exp_wr(5'd3, 32'h30); cyc();
      pri(5'd3, 32'h31); sec(5'd9, 32'h22); exp_wr(5'd3, 32'h31); cyc();
      chk("full_ready", {31'd0, bus.sec_ready}, 32'd0);
      chk("pending_r9", bus.pending_mask, 32'h00000200);
      pri(5'd3, 32'h32); sec(5'd10, 32'h99); exp_wr(5'd3, 32'h32); cyc();
      chk("full_hold_ready", {31'd0, bus.sec_ready}, 32'd0);
      idle();
      exp_wr(5'd9, 32'h11);
      exp_wr(5'd9, 32'h22);
      repeat (4) cyc();
      chk("drain_ready", {31'd0, bus.sec_ready}, 32'd1);
      chk("drain_mask", bus.pending_mask, 32'd0);

      // Primary overwrites a queued register: queued value must never appear.
      pri(5'd3, 32'h40); sec(5'd4, 32'hAA); exp_wr(5'd3, 32'h40); cyc();
      bus.sec_valid = 1'b0;
      chk("pending_r4", bus.pending_mask, 32'h00000010);
      pri(5'd4, 32'hBB); exp_wr(5'd4, 32'hBB); cyc();
      chk("kill_mask", bus.pending_mask, 32'd0);
      idle();
      repeat (3) cyc();

      // Push killed in the same cycle by a primary write to the same register.
      pri(5'd6, 32'h66); sec(5'd6, 32'h77); exp_wr(5'd6, 32'h66); cyc();
      idle();
      chk("push_kill_mask", bus.pending_mask, 32'd0);
      repeat (3) cyc();

      // Link write kills a queued r31.
      pri(5'd3, 32'h50); sec(5'd31, 32'hEE); exp_wr(5'd3, 32'h50); cyc();
      idle();
      chk("pending_r31", bus.pending_mask, 32'h80000000);
      bus.jal = 1'b1; bus.pc = 32'h200; exp_wr(5'd31, 32'h202); cyc();
      idle();
      chk("jal_kill_mask", bus.pending_mask, 32'd0);
      repeat (3) cyc();

      // Register 0 from both sources: no write ever, FIFO drains.
      pri(5'd0, 32'h1); sec(5'd0, 32'h5); cyc();
      pri(5'd2, 32'h22); sec(5'd0, 32'h6); exp_wr(5'd2, 32'h22); cyc();
      chk("r0_live_mask", bus.pending_mask, 32'h00000001);
      idle();
      repeat (3) cyc();
      chk("r0_drain_mask", bus.pending_mask, 32'd0);
      chk("r0_drain_ready", {31'd0, bus.sec_ready}, 32'd1);

`ifdef REGWB_STARVE_GUARD_EN
      // Busy primary with one queued entry: stall pulses 8 cycles after the push.
      pri(5'd3, 32'h60); sec(5'd8, 32'h88); exp_wr(5'd3, 32'h60); cyc();
      bus.sec_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         pri(5'd3, 32'h60 + i);
         exp_wr(5'd3, 32'h60 + i);
         cyc();
         chk("stall_pulse", {31'd0, bus.pri_stall}, {31'd0, (i == 8)});
      end
      pri(5'd3, 32'h6F);
      exp_wr(5'd8, 32'h88);
      cyc();
      chk("stall_clear", {31'd0, bus.pri_stall}, 32'd0);
      chk("stall_pop_we", {31'd0, bus.signal_reg_write}, 32'd1);
      idle();
      cyc();
`else
      // Without the guard a busy primary holds the FIFO off indefinitely.
      stall_seen = 1'b0;
      pri(5'd3, 32'h60); sec(5'd8, 32'h88); exp_wr(5'd3, 32'h60); cyc();
      bus.sec_valid = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         pri(5'd3, 32'h60 + i);
         exp_wr(5'd3, 32'h60 + i);
         cyc();
         stall_seen = stall_seen | bus.pri_stall;
      end
      chk("no_guard_stall", {31'd0, stall_seen}, 32'd0);
      chk("starved_mask", bus.pending_mask, 32'h00000100);
      idle();
      exp_wr(5'd8, 32'h88);
      repeat (3) cyc();
`endif

      // Reset mid-transfer with a full FIFO and live inputs.
      pri(5'd3, 32'h70); sec(5'd11, 32'hB1); exp_wr(5'd3, 32'h70); cyc();
      pri(5'd3, 32'h71); sec(5'd11, 32'hB2); exp_wr(5'd3, 32'h71); cyc();
      rst = 1'b1;
      pri(5'd3, 32'h72); sec(5'd11, 32'hB3);
      cyc();
      chk("mid_rst_we",    {31'd0, bus.signal_reg_write}, 32'd0);
      chk("mid_rst_reg",   {27'd0, bus.write_reg}, 32'd0);
      chk("mid_rst_data",  bus.write_data, 32'd0);
      chk("mid_rst_mask",  bus.pending_mask, 32'd0);
      chk("mid_rst_stall", {31'd0, bus.pri_stall}, 32'd0);
      chk("mid_rst_ready", {31'd0, bus.sec_ready}, 32'd1);
      rst = 1'b0;
      idle();
      repeat (4) cyc();

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_writeback_ctrl.md
# reg_writeback_ctrl

Write-side controller for the processor's 32×32 register file. It merges three result sources onto the register file's single write port (`signal_reg_write`/`write_reg`/`write_data`):
- single-cycle datapath results,
- `jal` link writes,
- results from a long-latency unit (mult/div), buffered in a small FIFO.

It sits between the datapath/execution units and the register file. It enforces write priority and program order, and publishes which registers have writes still pending.

## Interface
Parameters:
- `DEPTH`, 2, secondary FIFO entries (power of two, 2..8)
- `STARVE_LIMIT`, 8, cycles a non-empty FIFO may wait before the starvation guard fires (used only with the guard compiled in)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pri_valid`  in  1  datapath result valid this cycle
- `pri_reg`  in  5  datapath destination register
- `pri_data`  in  32  datapath result
- `jal`  in  1  link write request this cycle
- `pc`  in  32  current pc, used for the link value
- `sec_valid`  in  1  long-latency result offered
- `sec_ready`  out  1  FIFO can accept; transfer when `sec_valid && sec_ready`
- `sec_reg`  in  5  long-latency destination register
- `sec_data`  in  32  long-latency result
- `signal_reg_write`  out  1  register-file write enable
- `write_reg`  out  5  register-file write address
- `write_data`  out  32  register-file write data
- `pending_mask`  out  32  bit n set when a live FIFO entry targets register n
- `pri_stall`  out  1  datapath must hold; `pri_valid`/`jal` are ignored while high

## Operation
- Each cycle, at most one write is selected. Priority: `jal` > `pri_valid` > FIFO head.
- `jal` write: `write_reg`=31, `write_data`=`pc`+2 (32-bit wrap). If `pri_valid` is asserted in the same cycle, the `pri` write is dropped.
- Any selected write with destination register 0 is suppressed: `signal_reg_write` stays 0. A register-0 FIFO head is still popped.
- `sec` writes to register 0 are accepted and then discarded on pop.
- FIFO head pops only in a cycle with no `jal` and no `pri_valid`, or while `pri_stall` is high.
- Order kill:
  - When a `jal` or `pri` write to register r is selected, every live FIFO entry with destination r is invalidated. It occupies its slot until popped, but never writes.
  - An entry pushed in the same cycle with destination r is also killed.
- `sec_ready` = FIFO not full, computed from registered occupancy. A pop in the current cycle does not raise it in the same cycle.
- `pending_mask` is the OR of the one-hot destinations of live (not killed) entries. It updates the cycle after a push, pop or kill.

## Timing
- All outputs are registered. A write selected in cycle t appears on `signal_reg_write`/`write_reg`/`write_data` in cycle t+1, for exactly one cycle.
- Latency:
  - `pri` to write port: 1 cycle.
  - `sec` accepted at t with an idle primary: pops at t+1, appears on the write port at t+2.
- Push and pop in the same cycle with the FIFO full: the pop is honoured. The push is honoured only if `sec_ready` was high, so no overflow is possible.
- Read-pointer and write-pointer wrap modulo `DEPTH`.
- Reset (`rst` high at a clock edge):
  - `signal_reg_write`=0, `write_reg`=0, `write_data`=0, `pending_mask`=0, `pri_stall`=0, `sec_ready`=1 on the next cycle.
  - FIFO is emptied and in-flight entries are lost.
  - The starvation counter is cleared.
  - Reset asserted mid-transfer overrides any push or pop in that cycle.

## Configuration
- `REGWB_STARVE_GUARD_EN` defined:
  - A counter increments each cycle the FIFO is non-empty and no pop occurs, and clears on a pop.
  - When the count reaches `STARVE_LIMIT`, `pri_stall` is driven high for exactly one cycle. In that cycle the head pops.
- Not defined:
  - `pri_stall` is tied to 0 and no counter exists.
  - A continuously busy primary can starve the FIFO indefinitely. This is allowed.

## Structure
- Package `regwb_pkg`:
  - `REG_LINK`=5'd31
  - `LINK_OFFSET`=32'd2
  - `REG_ZERO`=5'd0
  - typedef `regwb_entry_t` {`valid`, `killed`, `reg`[4:0], `data`[31:0]}
- Sub-module `regwb_fifo`: storage, pointers, occupancy, per-entry kill compare, and `pending_mask` generation.
- Top level: priority select, link adder, output registers, and the starvation guard.

## Test plan
- Reset, then `pri_valid`=1, `pri_reg`=5, `pri_data`=0xDEADBEEF → next cycle `signal_reg_write`=1, `write_reg`=5, `write_data`=0xDEADBEEF; one cycle later `signal_reg_write`=0.
- `jal`=1, `pc`=0x100, with `pri_valid`=1 to r7 in the same cycle → only the write r31 ← 0x102 is issued; r7 is never written.
- Push r9=0x11 and r9=0x22 into the FIFO while the primary writes r3 continuously → `sec_ready`=0 after 2 pushes and `pending_mask`=0x200. When the primary goes idle, r9 ← 0x11 is written, then r9 ← 0x22.
- FIFO holds r4=0xAA, then the primary writes r4=0xBB → `pending_mask` bit 4 clears and r4 ← 0xAA never reaches the port.
- `pri_valid` to r0 and `sec` to r0 → `signal_reg_write` stays 0 throughout, and the FIFO drains to empty.
- With `REGWB_STARVE_GUARD_EN`, `STARVE_LIMIT`=8, primary held busy and one entry queued → `pri_stall` pulses high once 8 cycles after the push, and that entry is written on the following cycle. Assert `rst` mid-sequence → all outputs read 0 and `sec_ready`=1.
